// File: rtl/traffic_timer.sv
// traffic_timer: times green/yellow phases with a prescaled tick and pulses count_done_g/_y on expiry.
// Define TRAFFIC_TIMER_RUNTIME_DUR_EN to take phase durations from the green_dur/yellow_dur ports.
`timescale 1ns/1ps
module traffic_timer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int GREEN_SEC  = 25,
  parameter int YELLOW_SEC = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             count_g,
  input  logic             count_y,
`ifdef TRAFFIC_TIMER_RUNTIME_DUR_EN
  input  logic [CNT_W-1:0] green_dur,
  input  logic [CNT_W-1:0] yellow_dur,
`endif
  output logic             count_done_g,
  output logic             count_done_y,
  output logic [CNT_W-1:0] remain
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_GREEN  = 2'd1,
    MODE_YELLOW = 2'd2
  } mode_e;

  mode_e            mode;
  mode_e            prev_mode_q;
  logic [PRE_W-1:0] presc_q;
  logic [CNT_W-1:0] remain_q;
  logic             done_g_q;
  logic             done_y_q;

  logic [CNT_W-1:0] green_raw;
  logic [CNT_W-1:0] yellow_raw;
  logic [CNT_W-1:0] green_load;
  logic [CNT_W-1:0] yellow_load;
  logic             tick;

  // The invalid request 11 falls into the default and behaves exactly like idle.
  always_comb begin
    mode = MODE_IDLE;
    case ({count_g, count_y})
      2'b10:   mode = MODE_GREEN;
      2'b01:   mode = MODE_YELLOW;
      default: mode = MODE_IDLE;
    endcase
  end

`ifdef TRAFFIC_TIMER_RUNTIME_DUR_EN
  assign green_raw  = green_dur;
  assign yellow_raw = yellow_dur;
`else
  assign green_raw  = CNT_W'(GREEN_SEC);
  assign yellow_raw = CNT_W'(YELLOW_SEC);
`endif

  // A zero-length phase would never produce a done pulse, so it is stretched to one tick.
  assign green_load  = (green_raw == '0)  ? CNT_W'(1) : green_raw;
  assign yellow_load = (yellow_raw == '0) ? CNT_W'(1) : yellow_raw;

  assign tick = (presc_q == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_mode_q <= MODE_IDLE;
      presc_q     <= '0;
      remain_q    <= '0;
      done_g_q    <= 1'b0;
      done_y_q    <= 1'b0;
    end else begin
      prev_mode_q <= mode;
      done_g_q    <= 1'b0;
      done_y_q    <= 1'b0;
      if (mode == MODE_IDLE) begin
        presc_q  <= '0;
        remain_q <= '0;
      end else if (mode != prev_mode_q) begin
        presc_q  <= '0;
        remain_q <= (mode == MODE_GREEN) ? green_load : yellow_load;
      end else begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        // Done fires only on the 1->0 step, so a phase parked at 0 stays silent.
        if (tick && (remain_q != '0)) begin
          remain_q <= remain_q - 1'b1;
          if (remain_q == CNT_W'(1)) begin
            done_g_q <= (mode == MODE_GREEN);
            done_y_q <= (mode == MODE_YELLOW);
          end
        end
      end
    end
  end

  assign count_done_g = done_g_q;
  assign count_done_y = done_y_q;
  assign remain       = remain_q;

endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: randomized scoreboard bench for traffic_timer against a phase-arithmetic model.
`timescale 1ns/1ps
module tb_traffic_timer;

  localparam int TD = 4;
  localparam int GS = 3;
  localparam int YS = 2;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          count_g = 1'b0;
  logic          count_y = 1'b0;
  logic          doneG;
  logic          doneY;
  logic [CW-1:0] remain;
`ifdef TRAFFIC_TIMER_RUNTIME_DUR_EN
  logic [CW-1:0] greenDur = CW'(GS);
  logic [CW-1:0] yellowDur = CW'(YS);
`endif

  traffic_timer #(
    .TICK_DIV  (TD),
    .GREEN_SEC (GS),
    .YELLOW_SEC(YS),
    .CNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .count_g     (count_g),
    .count_y     (count_y),
`ifdef TRAFFIC_TIMER_RUNTIME_DUR_EN
    .green_dur   (greenDur),
    .yellow_dur  (yellowDur),
`endif
    .count_done_g(doneG),
    .count_done_y(doneY),
    .remain      (remain)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int assertCount = 0;
  int failCount = 0;

  typedef struct {
    int when;
    int kind;
  } doneEv_t;
  doneEv_t expQ[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  function automatic int modeOf(input logic g, input logic y);
    case ({g, y})
      2'b10:   return 1;
      2'b01:   return 2;
      default: return 0;
    endcase
  endfunction

  // Phase duration as loaded: truncated to CW bits, with zero promoted to one tick.
  function automatic int loadDur(input int m);
    int raw;
`ifdef TRAFFIC_TIMER_RUNTIME_DUR_EN
    raw = (m == 1) ? int'(greenDur) : int'(yellowDur);
`else
    raw = (m == 1) ? GS : YS;
`endif
    raw = raw % (1 << CW);
    return (raw == 0) ? 1 : raw;
  endfunction

  // Reference model: a phase loaded at cycle L with duration D shows D - floor((c-L-1)/TD),
  // clamped at 0, and pulses done at L+D*TD+1 provided the mode is still held at L+D*TD.
  int prevMode = 0;
  int phActive = 0;
  int phL = 0;
  int phD = 0;
  int mNow = 0;
  int expRemain = 0;
  always @(negedge clk) begin
    mNow = modeOf(count_g, count_y);
    if (!rst_n || !phActive) expRemain = 0;
    else begin
      expRemain = phD - (cyc - 1 - phL) / TD;
      if (expRemain < 0) expRemain = 0;
    end
    checkOutput("remain", 32'(remain), 32'(expRemain));
    if (!rst_n) begin
      phActive = 0;
      prevMode = 0;
      expQ.delete();
    end else begin
      if (mNow == 0) phActive = 0;
      else if (mNow != prevMode) begin
        phActive = 1;
        phL = cyc;
        phD = loadDur(mNow);
      end else if (phActive != 0 && cyc == phL + phD * TD) begin
        expQ.push_back('{cyc + 1, mNow});
      end
      prevMode = mNow;
    end
  end

  // Monitor: every done pulse must match the oldest expected event in cycle and colour.
  int kindSeen;
  always @(negedge clk) begin
    checkOutput("doneExclusive", 32'(doneG & doneY), 32'd0);
    while (expQ.size() > 0 && expQ[0].when < cyc) begin
      checkOutput("doneMissed", 32'(cyc), 32'(expQ[0].when));
      void'(expQ.pop_front());
    end
    if (doneG || doneY) begin
      kindSeen = doneG ? 1 : 2;
      if (expQ.size() == 0) checkOutput("doneUnexpected", 32'(kindSeen), 32'd0);
      else begin
        checkOutput("doneCycle", 32'(cyc), 32'(expQ[0].when));
        checkOutput("doneKind", 32'(kindSeen), 32'(expQ[0].kind));
        void'(expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic g, input logic y, input int holdCycles);
    @(posedge clk);
    #1;
    count_g = g;
    count_y = y;
    repeat (holdCycles - 1) @(posedge clk);
  endtask

  // Controller loop: each phase starts after the previous done and must last D*TD+2 cycles.
  task automatic runController(input int phases);
    int kind;
    int start;
    int waited;
    int seenKind;
    kind = 2;
    for (int p = 0; p < phases; p++) begin
      @(posedge clk);
      #1;
      count_g = (kind == 1);
      count_y = (kind == 2);
      start = cyc;
      waited = 0;
      seenKind = 0;
      while (seenKind == 0 && waited < 200) begin
        @(negedge clk);
        waited++;
        if (doneG) seenKind = 1;
        else if (doneY) seenKind = 2;
      end
      if (seenKind == 0) checkOutput("loopTimeout", 32'(waited), 32'd0);
      else begin
        checkOutput("loopDoneKind", 32'(seenKind), 32'(kind));
        checkOutput("loopPhaseLen", 32'(cyc + 1 - start), 32'(loadDur(kind) * TD + 2));
      end
      kind = (kind == 1) ? 2 : 1;
    end
  endtask

  initial begin
    logic g;
    logic y;
    int sel;
    #1;
    rst_n = 1'b0;
    #2;
    checkOutput("resetRemain", 32'(remain), 32'd0);
    checkOutput("resetDoneG", 32'(doneG), 32'd0);
    checkOutput("resetDoneY", 32'(doneY), 32'd0);
    repeat (3) @(posedge clk);

    $display("[TB] reset release into green, then hold green well past done");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    count_g = 1'b1;
    repeat (55) @(posedge clk);

    $display("[TB] closed loop Y/G/Y/G");
    runController(4);
    applyStimulus(1'b0, 1'b0, 3);

    $display("[TB] green switched to yellow mid-phase");
    applyStimulus(1'b1, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 16);
    applyStimulus(1'b0, 1'b0, 3);

    $display("[TB] reset asserted during green");
    applyStimulus(1'b1, 1'b0, 9);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midRstRemain", 32'(remain), 32'd0);
    checkOutput("midRstDoneG", 32'(doneG), 32'd0);
    checkOutput("midRstDoneY", 32'(doneY), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    $display("[TB] invalid request 11");
    applyStimulus(1'b1, 1'b1, 20);

`ifdef TRAFFIC_TIMER_RUNTIME_DUR_EN
    $display("[TB] runtime green duration of zero");
    applyStimulus(1'b0, 1'b0, 2);
    greenDur = '0;
    applyStimulus(1'b1, 1'b0, 10);
    greenDur = CW'(GS);
    applyStimulus(1'b0, 1'b0, 2);
`endif

    $display("[TB] randomized request sequence");
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 3));
      g = (sel == 1) || (sel == 3);
      y = (sel == 2) || (sel == 3);
      applyStimulus(g, y, int'($urandom_range(1, 20)));
    end

    applyStimulus(1'b0, 1'b0, 4);
    @(negedge clk);
    checkOutput("pendingDone", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/traffic_timer.md
# traffic_timer

Phase timer paired with the two-road traffic light controller. It consumes the controller's phase-count requests, `count_g` and `count_y`, and times each phase with a prescaled one-second tick. It returns single-cycle `count_done_g` / `count_done_y` pulses that advance the controller's state machine. It also exposes the seconds remaining in the current phase for a countdown display.

## Interface
- `TICK_DIV`, default 50_000_000: clk cycles per timer tick. Must be ≥ 2.
- `GREEN_SEC`, default 25: green phase length in ticks. A value of 0 is treated as 1.
- `YELLOW_SEC`, default 3: yellow phase length in ticks. A value of 0 is treated as 1.
- `CNT_W`, default 8: width of the remaining-ticks counter. Must hold `max(GREEN_SEC, YELLOW_SEC)`.
- `clk`, input, 1: single clock. All state is updated on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `count_g`, input, 1: controller requests green-phase timing.
- `count_y`, input, 1: controller requests yellow-phase timing.
- `count_done_g`, output, 1: one-cycle pulse when the green phase expires.
- `count_done_y`, output, 1: one-cycle pulse when the yellow phase expires.
- `remain`, output, CNT_W: ticks left in the current phase, for the display.

## Operation
- Mode is derived from the inputs:
  - 10 = GREEN
  - 01 = YELLOW
  - 00 = IDLE
  - 11 = INVALID, handled as IDLE
- A registered `prev_mode` holds the previous cycle's mode. It resets to IDLE.
- Load: when mode ≠ `prev_mode` and mode is GREEN or YELLOW:
  - `remain` ← that phase's duration.
  - Prescaler ← 0.
  - No done pulse is issued.
- IDLE or INVALID:
  - `remain` ← 0 and prescaler ← 0.
  - Both done outputs stay 0.
- Run: when mode = `prev_mode` and mode is GREEN or YELLOW:
  - Prescaler counts 0 to TICK_DIV−1 and wraps.
  - A tick occurs in the cycle the prescaler equals TICK_DIV−1.
  - On a tick with `remain` > 0, `remain` decrements.
  - On a tick with `remain` = 1, the done flag for the current mode is registered high for exactly one cycle.
- Done is generated only on the 1→0 transition of `remain`:
  - If the controller does not advance, `remain` holds at 0.
  - No further done pulses are issued until the next load.
- `count_done_g` and `count_done_y` are never high in the same cycle.
- A mode change mid-phase (e.g. G→Y early) reloads immediately and discards the old count without a done pulse.
- `remain` width rule: durations are truncated to CNT_W bits at load. If the truncated value is 0, 1 is loaded.

## Timing
- Reset state:
  - `count_done_g` = 0, `count_done_y` = 0, `remain` = 0.
  - Prescaler = 0, `prev_mode` = IDLE.
- Reset asserted mid-phase aborts the phase immediately, and no pulse is issued.
- Let L be the first cycle a new mode is visible on the inputs. Load takes effect at the edge ending L.
- Ticks occur in cycles L+k·TICK_DIV, for k ≥ 1.
- Done is high in cycle L+D·TICK_DIV+1, where D is the loaded duration.
- Done is a registered output and is sampled combinationally by the controller. The controller changes phase at the edge ending the done cycle.
- The next mode is therefore visible at L+D·TICK_DIV+2, so the total phase length is D·TICK_DIV+2 cycles.
- After reset the controller presents GREEN, so the first load occurs in the first cycle after `rst_n` deasserts.

## Configuration
- `TRAFFIC_TIMER_RUNTIME_DUR_EN`
- When defined, two extra input ports are added:
  - `green_dur`, CNT_W wide.
  - `yellow_dur`, CNT_W wide.
- Each port is sampled only in the load cycle, with the same 0→1 rule applied. Changes to the port mid-phase have no effect until the next load.
- When not defined, those ports are absent and the durations come from GREEN_SEC and YELLOW_SEC.

## Test plan
All scenarios use TICK_DIV=4, GREEN_SEC=3, YELLOW_SEC=2.
- Reset release, then `count_g`=1 from cycle L:
  - `remain` = 3 at L+1.
  - Decrements to 2 / 1 / 0 at L+5 / L+9 / L+13.
  - `count_done_g` high only in cycle L+13.
- Closed loop with the controller model through G→Y→G→Y:
  - Green phase length is 14 cycles; yellow phase length is 10 cycles.
  - Exactly one done pulse per phase, and `count_done_g` and `count_done_y` are never asserted together.
- Hold `count_g`=1 for 40 cycles after done:
  - `remain` stays at 0.
  - No second `count_done_g`.
- `count_g` switched to `count_y` at L+6, mid-green:
  - No `count_done_g`.
  - `remain` = 2 at L+7.
  - `count_done_y` pulses at L+6+2·4+1 = L+15.
- `rst_n` asserted at L+8, during green:
  - All outputs are 0 asynchronously.
  - After release, `remain` reloads to 3 with a fresh prescaler.
- Inputs at 11 for 20 cycles:
  - `remain` = 0 and no done pulses.
- With `TRAFFIC_TIMER_RUNTIME_DUR_EN` and `green_dur`=0:
  - Done fires at L+5.
